// File: rtl/cu_multicycle_param.sv
// ---------------------------------------------------------------------------
// cu_multicycle_param
//   Parametrised multicycle control unit. Fetches instructions over a shared
//   RAM bus, decodes them against an internal register file, drives an
//   external combinational ALU and executes LOAD, STORE, MOV, JMP, BZ, HALT
//   and ALU operations.
//
//   Optional build macro: CU_R0_ZERO_EN
//     defined   -> r[0] always reads 0 and writes to it are discarded
//     undefined -> r[0] is an ordinary register
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   1 = advance, 0 = hold every register (including requests)
//   mem_addr   out  RAM address
//   mem_rd     out  read request, held until mem_ready
//   mem_wr     out  write request, held until mem_ready
//   mem_wdata  out  store data
//   mem_rdata  in   read data, sampled when mem_ready=1 during a read
//   mem_ready  in   completes the current request
//   alu_op     out  opcode presented to the ALU
//   alu_a      out  ALU operand A = r[rs1]
//   alu_b      out  ALU operand B = r[rs2]
//   alu_result in   combinational ALU result
//   halted     out  high while in the HALT state
//   pc_out     out  current program counter
//
// Memory handshake: a request (mem_rd or mem_wr, never both) is raised by
// this unit and held with stable mem_addr/mem_wdata until a cycle in which
// mem_ready=1 and enable=1; that edge completes the transfer and the request
// drops on the same edge. mem_ready with no request pending is ignored.
// ---------------------------------------------------------------------------
module cu_multicycle_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int OP_W     = 4,
  parameter int NUM_REGS = 8,
  parameter int PC_RESET = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int REG_AW = $clog2(NUM_REGS);

  localparam logic [OP_W-1:0]   OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0]   OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0]   OP_MOV   = OP_W'(2);
  localparam logic [OP_W-1:0]   OP_JMP   = OP_W'(3);
  localparam logic [OP_W-1:0]   OP_BZ    = OP_W'(4);
  localparam logic [OP_W-1:0]   OP_HALT  = {OP_W{1'b1}};
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(PC_RESET);

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [DATA_W-1:0]   r_ir, w_ir_nxt;
  logic [DATA_W-1:0]   r_rf [NUM_REGS];
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                r_mem_rd, w_mem_rd_nxt;
  logic                r_mem_wr, w_mem_wr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [OP_W-1:0]     r_alu_op, w_alu_op_nxt;
  logic [DATA_W-1:0]   r_alu_a, w_alu_a_nxt;
  logic [DATA_W-1:0]   r_alu_b, w_alu_b_nxt;
  logic                r_halted, w_halted_nxt;

  logic                w_rf_we, w_rf_we_eff;
  logic [DATA_W-1:0]   w_rf_wdata;

  // Instruction fields; rs1/rs2 overlap the addr field by design.
  logic [OP_W-1:0]     w_op;
  logic [REG_AW-1:0]   w_rd, w_rs1, w_rs2;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_rd_val, w_rs1_val, w_rs2_val;
  logic                w_unused_ir;

  assign w_op   = r_ir[OP_W-1:0];
  assign w_rd   = r_ir[OP_W +: REG_AW];
  assign w_rs1  = r_ir[OP_W+REG_AW +: REG_AW];
  assign w_rs2  = r_ir[OP_W+2*REG_AW +: REG_AW];
  assign w_addr = r_ir[OP_W+REG_AW +: ADDR_W];
  // Upper IR bits beyond the widest field are don't-care.
  assign w_unused_ir = ^r_ir;

`ifdef CU_R0_ZERO_EN
  assign w_rd_val    = (w_rd  == '0) ? '0 : r_rf[w_rd];
  assign w_rs1_val   = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
  assign w_rs2_val   = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
  assign w_rf_we_eff = w_rf_we && (w_rd != '0);
`else
  assign w_rd_val    = r_rf[w_rd];
  assign w_rs1_val   = r_rf[w_rs1];
  assign w_rs2_val   = r_rf[w_rs2];
  assign w_rf_we_eff = w_rf_we;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ir_nxt        = r_ir;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_rd_nxt    = r_mem_rd;
    w_mem_wr_nxt    = r_mem_wr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_alu_op_nxt    = r_alu_op;
    w_alu_a_nxt     = r_alu_a;
    w_alu_b_nxt     = r_alu_b;
    w_halted_nxt    = r_halted;
    w_rf_we         = 1'b0;
    w_rf_wdata      = alu_result;

    case (r_state)
      S_FETCH: begin
        w_mem_addr_nxt = r_pc;
        w_mem_rd_nxt   = 1'b1;
        w_pc_nxt       = r_pc + ADDR_W'(1);
        w_state_nxt    = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (mem_ready) begin
          w_ir_nxt     = mem_rdata;
          w_mem_rd_nxt = 1'b0;
          w_state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_op)
          OP_LOAD: begin
            w_mem_addr_nxt = w_addr;
            w_mem_rd_nxt   = 1'b1;
            w_state_nxt    = S_MEM_WAIT;
          end
          OP_STORE: begin
            w_mem_addr_nxt  = w_addr;
            w_mem_wdata_nxt = w_rd_val;
            w_mem_wr_nxt    = 1'b1;
            w_state_nxt     = S_MEM_WAIT;
          end
          OP_MOV: begin
            w_rf_we     = 1'b1;
            w_rf_wdata  = w_rs1_val;
            w_state_nxt = S_FETCH;
          end
          OP_JMP: begin
            w_pc_nxt    = w_addr;
            w_state_nxt = S_FETCH;
          end
          OP_BZ: begin
            if (w_rd_val == '0) w_pc_nxt = w_addr;
            w_state_nxt = S_FETCH;
          end
          OP_HALT: begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = S_HALT;
          end
          default: begin
            w_alu_op_nxt = w_op;
            w_alu_a_nxt  = w_rs1_val;
            w_alu_b_nxt  = w_rs2_val;
            w_state_nxt  = S_EXEC;
          end
        endcase
      end
      S_EXEC: begin
        w_rf_we     = 1'b1;
        w_rf_wdata  = alu_result;
        w_state_nxt = S_FETCH;
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          // Only a LOAD writes back; a STORE just retires.
          if (r_mem_rd) begin
            w_rf_we    = 1'b1;
            w_rf_wdata = mem_rdata;
          end
          w_mem_rd_nxt = 1'b0;
          w_mem_wr_nxt = 1'b0;
          w_state_nxt  = S_FETCH;
        end
      end
      S_HALT: begin
        w_halted_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_pc        <= PC_RST;
      r_ir        <= '0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_halted    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else if (enable) begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_rd    <= w_mem_rd_nxt;
      r_mem_wr    <= w_mem_wr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_alu_op    <= w_alu_op_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_halted    <= w_halted_nxt;
      if (w_rf_we_eff) r_rf[w_rd] <= w_rf_wdata;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_mem_wdata;
  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign halted    = r_halted;
  assign pc_out    = r_pc;

endmodule
